// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the banked single-port RAM wrapper.
package sp_ram_pkg;

    localparam int unsigned NUM_BANKS_DEF = 4;
    localparam int unsigned BANK_BITS     = $clog2(NUM_BANKS_DEF);
    localparam int unsigned MASK_MAX_W    = 256;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RMW  = 1'b1
    } sp_ram_state_e;

    // Callers zero-extend their byte enables and keep the low DATA_WIDTH bits of the result.
    function automatic logic [MASK_MAX_W-1:0] be_to_mask(input logic [MASK_MAX_W/8-1:0] be);
        logic [MASK_MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MASK_MAX_W/8; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sp_ram_banked_wrap_sp_ram.sv
// Single-port RAM macro model (sp_ram): registered read, byte-enable write, contents not reset.
module sp_ram #(
    parameter int unsigned DEPTH      = 2048,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int unsigned i = 0; i < DATA_WIDTH/8; i++) begin
                    if (be[i]) begin
                        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sp_ram_banked_wrap.sv
// Word-interleaved multi-bank single-port RAM with req/gnt/rvalid protocol and RMW byte writes.
// Optional SP_RAM_OUT_REG_EN adds one output register stage on rvalid_o/rdata_o.
module sp_ram_banked_wrap
    import sp_ram_pkg::*;
#(
    parameter int unsigned RAM_SIZE   = 32768,
    parameter int unsigned NUM_BANKS  = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter bit          BYTE_WR    = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned BE_W       = DATA_WIDTH / 8;
    localparam int unsigned OFF_W      = $clog2(BE_W);
    localparam int unsigned BK_BITS    = $clog2(NUM_BANKS);
    localparam int unsigned BK_W       = (BK_BITS == 0) ? 1 : BK_BITS;
    localparam int unsigned ROW_W      = ADDR_WIDTH - OFF_W - BK_BITS;
    localparam int unsigned BANK_DEPTH = RAM_SIZE / NUM_BANKS / BE_W;

    sp_ram_state_e         state_q, state_d;
    logic [BK_W-1:0]       bank_q, bank_d;
    logic [ROW_W-1:0]      row_q, row_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  rsp_rd_q, rsp_rd_d;

    logic [BK_W-1:0]       req_bank;
    logic [ROW_W-1:0]      req_row;
    logic                  partial_wr;
    logic                  zero_be_wr;
    logic [NUM_BANKS-1:0]  mac_en;
    logic                  mac_we;
    logic [BE_W-1:0]       mac_be;
    logic [ROW_W-1:0]      mac_row;
    logic [DATA_WIDTH-1:0] mac_wdata;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic [MASK_MAX_W/8-1:0] be_ext;
    logic [MASK_MAX_W-1:0] mask_full;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  unused_addr;

    assign unused_addr = ^addr_i[OFF_W-1:0];
    assign req_row     = addr_i[ADDR_WIDTH-1 -: ROW_W];

    if (BK_BITS == 0) begin : g_one_bank
        assign req_bank = '0;
    end else begin : g_multi_bank
        assign req_bank = addr_i[OFF_W +: BK_BITS];
    end

    assign zero_be_wr = we_i & ~|be_i;
    assign partial_wr = we_i & ~BYTE_WR & |be_i & ~&be_i;

    always_comb begin
        be_ext           = '0;
        be_ext[BE_W-1:0] = be_q;
        mask_full        = be_to_mask(be_ext);
        mask             = mask_full[DATA_WIDTH-1:0];
        merged           = (bank_rdata[bank_q] & ~mask) | (wdata_q & mask);
    end

    // Macro enables depend on state_q, so an async reset during RMW kills the merge write.
    always_comb begin
        state_d   = state_q;
        bank_d    = bank_q;
        row_d     = row_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rvalid_d  = 1'b0;
        rsp_rd_d  = 1'b0;
        gnt_o     = 1'b0;
        mac_en    = '0;
        mac_we    = 1'b0;
        mac_be    = be_i;
        mac_row   = req_row;
        mac_wdata = wdata_i;
        case (state_q)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    bank_d   = req_bank;
                    rsp_rd_d = ~we_i;
                    if (partial_wr) begin
                        state_d          = RMW;
                        row_d            = req_row;
                        be_d             = be_i;
                        wdata_d          = wdata_i;
                        mac_en[req_bank] = 1'b1;
                    end else begin
                        rvalid_d = 1'b1;
                        if (!zero_be_wr) begin
                            mac_en[req_bank] = 1'b1;
                            mac_we           = we_i;
                        end
                    end
                end
            end
            RMW: begin
                mac_en[bank_q] = 1'b1;
                mac_we         = 1'b1;
                mac_be         = '1;
                mac_row        = row_q;
                mac_wdata      = merged;
                rvalid_d       = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            bank_q   <= '0;
            row_q    <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            rsp_rd_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            bank_q   <= bank_d;
            row_q    <= row_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rsp_rd_q <= rsp_rd_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sp_ram #(
            .DEPTH      (BANK_DEPTH),
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_W     (ROW_W)
        ) u_ram (
            .clk   (clk),
            .en    (mac_en[b]),
            .we    (mac_we),
            .be    (mac_be),
            .addr  (mac_row),
            .wdata (mac_wdata),
            .rdata (bank_rdata[b])
        );
    end

    assign rsp_rdata = (rvalid_q && rsp_rd_q) ? bank_rdata[bank_q] : '0;

`ifdef SP_RAM_OUT_REG_EN
    logic                  out_rvalid_q, out_rvalid_d;
    logic [DATA_WIDTH-1:0] out_rdata_q, out_rdata_d;

    always_comb begin
        out_rvalid_d = rvalid_q;
        out_rdata_d  = rsp_rdata;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            out_rvalid_q <= 1'b0;
            out_rdata_q  <= '0;
        end else begin
            out_rvalid_q <= out_rvalid_d;
            out_rdata_q  <= out_rdata_d;
        end
    end

    assign rvalid_o = out_rvalid_q;
    assign rdata_o  = out_rdata_q;
`else
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rsp_rdata;
`endif

endmodule

// File: tb/tb_sp_ram_banked_wrap.sv
// Scoreboard bench for sp_ram_banked_wrap (BYTE_WR=0 so partial writes go through RMW).
module tb_sp_ram_banked_wrap;

`ifdef SP_RAM_OUT_REG_EN
    localparam int unsigned LAT_F = 2;
    localparam int unsigned LAT_R = 3;
`else
    localparam int unsigned LAT_F = 1;
    localparam int unsigned LAT_R = 2;
`endif

    logic        clk;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic [14:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;

    sp_ram_banked_wrap #(
        .RAM_SIZE   (32768),
        .NUM_BANKS  (4),
        .DATA_WIDTH (32),
        .ADDR_WIDTH (15),
        .BYTE_WR    (1'b0)
    ) dut (
        .clk      (clk),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o)
    );

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
        int unsigned id;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    int unsigned next_id = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented response is popped and compared against the scoreboard.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (rvalid_o) begin
                exp_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rvalid cyc=%0d rdata=%h required no response", cyc, rdata_o);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata_o !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL rsp%0d got data=%h cyc=%0d required data=%h cyc=%0d",
                                 e.id, rdata_o, cyc, e.data, e.cyc);
                    end
                end
            end else begin
                checks++;
                if (rdata_o !== 32'h0) begin
                    errors++;
                    $display("FAIL rdata_idle got %h required 00000000", rdata_o);
                end
            end
        end
    end

    task automatic access(input logic [14:0] a, input logic w, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input int unsigned lat, input int unsigned exp_stall, input bit push);
        int unsigned stall;
        exp_t e;
        req_i   = 1'b1;
        addr_i  = a;
        we_i    = w;
        be_i    = be;
        wdata_i = wd;
        stall   = 0;
        @(negedge clk);
        while (!gnt_o && stall < 20) begin
            stall++;
            @(negedge clk);
        end
        checks++;
        if (!gnt_o || stall != exp_stall) begin
            errors++;
            $display("FAIL grant addr=%h got stall=%0d gnt=%0b required stall=%0d gnt=1",
                     a, stall, gnt_o, exp_stall);
        end
        if (gnt_o && push) begin
            e.data = exp_rd;
            e.cyc  = cyc + lat;
            e.id   = next_id;
            next_id++;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_i = 1'b0;
        we_i  = 1'b0;
        be_i  = 4'h0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_i   = 1'b1;
        req_i   = 1'b0;
        addr_i  = '0;
        we_i    = 1'b0;
        be_i    = 4'h0;
        wdata_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid_o !== 1'b0 || rdata_o !== 32'h0 || gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got rvalid=%b rdata=%h gnt=%b required 0 00000000 0",
                     rvalid_o, rdata_o, gnt_o);
        end
        idle(1);

        // full write then read
        access(15'h10, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, LAT_F, 0, 1'b1);
        access(15'h10, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, LAT_F, 0, 1'b1);
        // be==0 write is acknowledged but leaves the word alone
        access(15'h10, 1'b1, 4'h0, 32'h12345678, 32'h0, LAT_F, 0, 1'b1);
        access(15'h10, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, LAT_F, 0, 1'b1);
        idle(3);

        // RMW: second access stalls one cycle and sees merged word
        access(15'h20, 1'b1, 4'hF, 32'h11223344, 32'h0, LAT_F, 0, 1'b1);
        access(15'h20, 1'b1, 4'b0010, 32'h0000AA00, 32'h0, LAT_R, 0, 1'b1);
        access(15'h20, 1'b0, 4'hF, 32'h0, 32'h1122AA44, LAT_F, 1, 1'b1);
        access(15'h30, 1'b1, 4'hF, 32'hA5A5A5A5, 32'h0, LAT_F, 0, 1'b1);
        access(15'h30, 1'b1, 4'b1001, 32'h11223344, 32'h0, LAT_R, 0, 1'b1);
        access(15'h30, 1'b0, 4'hF, 32'h0, 32'h11A5A544, LAT_F, 1, 1'b1);
        idle(3);

        // fill four banks, then back-to-back reads
        access(15'h00, 1'b1, 4'hF, 32'h0000_0A00, 32'h0, LAT_F, 0, 1'b1);
        access(15'h04, 1'b1, 4'hF, 32'h0000_0B04, 32'h0, LAT_F, 0, 1'b1);
        access(15'h08, 1'b1, 4'hF, 32'h0000_0C08, 32'h0, LAT_F, 0, 1'b1);
        access(15'h0C, 1'b1, 4'hF, 32'h0000_0D0C, 32'h0, LAT_F, 0, 1'b1);
        access(15'h00, 1'b0, 4'hF, 32'h0, 32'h0000_0A00, LAT_F, 0, 1'b1);
        access(15'h04, 1'b0, 4'hF, 32'h0, 32'h0000_0B04, LAT_F, 0, 1'b1);
        access(15'h08, 1'b0, 4'hF, 32'h0, 32'h0000_0C08, LAT_F, 0, 1'b1);
        access(15'h0C, 1'b0, 4'hF, 32'h0, 32'h0000_0D0C, LAT_F, 0, 1'b1);
        idle(4);

        // reset during RMW cycle: merge write dropped, no response
        access(15'h20, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, LAT_F, 0, 1'b1);
        idle(4);
        access(15'h20, 1'b1, 4'b0001, 32'h000000FF, 32'h0, LAT_R, 0, 1'b0);
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if (rvalid_o !== 1'b0 || gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL rmw_reset got rvalid=%b gnt=%b required 0 0", rvalid_o, gnt_o);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        idle(4);
        access(15'h20, 1'b0, 4'hF, 32'h0, 32'hCAFEF00D, LAT_F, 0, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d outstanding required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
